// File: rtl/regfile_cmd_sequencer.sv
// Doorbell-driven command sequencer: turns register-file CTRL/ARG writes into a req/ack
// client operation and posts tag, status, result and saturating counters back to read words.
module regfile_cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned CNT_W       = 16
) (
   input  logic        axi_aclk,
   input  logic        axi_aresetn,
   input  logic [31:0] ctrl_word,
   input  logic [31:0] arg_word,
   output logic [31:0] status_word,
   output logic [31:0] result_word,
   output logic [31:0] cnt_word,
   output logic        irq,
   output logic        cl_req,
   output logic [3:0]  cl_op,
   output logic [31:0] cl_arg,
   input  logic        cl_ack,
   input  logic        cl_done,
   input  logic        cl_err,
   input  logic [31:0] cl_result
);

   localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [3:0] ErrOk      = 4'd0;
   localparam logic [3:0] ErrClient  = 4'd1;
   localparam logic [3:0] ErrTimeout = 4'd2;
   localparam logic [3:0] ErrBadOp   = 4'd3;
   localparam logic [3:0] ErrAbort   = 4'd4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StDone  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        tag_q, tag_d;
   logic [3:0]        op_q, op_d;
   logic [31:0]       arg_q, arg_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic [3:0]        err_pend_q, err_pend_d;
   logic [31:0]       res_pend_q, res_pend_d;
   logic [7:0]        done_tag_q, done_tag_d;
   logic [3:0]        err_q, err_d;
   logic              busy_q, busy_d;
   logic              ovr_q, ovr_d;
   logic [31:0]       result_q, result_d;
   logic [CNT_W-1:0]  succ_q, succ_d;
   logic [CNT_W-1:0]  errc_q, errc_d;
   logic              irq_q, irq_d;

   logic [7:0] ctrl_tag;
   logic       abort;
   logic       done_evt;
   logic       tmo_evt;
   logic       unused_ctrl;

   assign ctrl_tag    = ctrl_word[31:24];
   assign abort       = ctrl_word[8];
   assign unused_ctrl = ^{ctrl_word[23:9], ctrl_word[7:4]};

   // A done strobe only counts once the client has accepted the request.
   assign done_evt = ((state_q == StIssue) && cl_ack && cl_done) ||
                     ((state_q == StWait) && cl_done);
   assign tmo_evt  = (TIMEOUT_CYC != 0) && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

   always_comb begin
      state_d    = state_q;
      tag_d      = tag_q;
      op_d       = op_q;
      arg_d      = arg_q;
      tmo_d      = tmo_q;
      err_pend_d = err_pend_q;
      res_pend_d = res_pend_q;
      done_tag_d = done_tag_q;
      err_d      = err_q;
      busy_d     = busy_q;
      ovr_d      = ovr_q;
      result_d   = result_q;
      succ_d     = succ_q;
      errc_d     = errc_q;
      irq_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (ctrl_tag != tag_q) begin
               tag_d      = ctrl_tag;
               op_d       = ctrl_word[3:0];
               arg_d      = arg_word;
               tmo_d      = '0;
               ovr_d      = 1'b0;
               busy_d     = 1'b1;
               res_pend_d = result_q;
               if (ctrl_word[3:0] == 4'd0) begin
                  state_d    = StDone;
                  err_pend_d = ErrBadOp;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue, StWait: begin
            tmo_d = tmo_q + TmoW'(1);
            if (ctrl_tag != tag_q) begin
               ovr_d = 1'b1;
            end
            if (done_evt) begin
               state_d    = StDone;
               err_pend_d = cl_err ? ErrClient : ErrOk;
               res_pend_d = cl_result;
            end else if (tmo_evt) begin
               state_d    = StDone;
               err_pend_d = ErrTimeout;
            end else if (abort) begin
               state_d    = StDone;
               err_pend_d = ErrAbort;
            end else if ((state_q == StIssue) && cl_ack) begin
               state_d = StWait;
            end
         end
         StDone: begin
            state_d    = StIdle;
            done_tag_d = tag_q;
            err_d      = err_pend_q;
            result_d   = res_pend_q;
            busy_d     = 1'b0;
            irq_d      = 1'b1;
            if (err_pend_q == ErrOk) begin
               if (succ_q != '1) begin
                  succ_d = succ_q + CNT_W'(1);
               end
            end else if (errc_q != '1) begin
               errc_d = errc_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q    <= StIdle;
         tag_q      <= '0;
         op_q       <= '0;
         arg_q      <= '0;
         tmo_q      <= '0;
         err_pend_q <= '0;
         res_pend_q <= '0;
         done_tag_q <= '0;
         err_q      <= '0;
         busy_q     <= 1'b0;
         ovr_q      <= 1'b0;
         result_q   <= '0;
         succ_q     <= '0;
         errc_q     <= '0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tag_q      <= tag_d;
         op_q       <= op_d;
         arg_q      <= arg_d;
         tmo_q      <= tmo_d;
         err_pend_q <= err_pend_d;
         res_pend_q <= res_pend_d;
         done_tag_q <= done_tag_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         ovr_q      <= ovr_d;
         result_q   <= result_d;
         succ_q     <= succ_d;
         errc_q     <= errc_d;
         irq_q      <= irq_d;
      end
   end

   assign status_word = {done_tag_q, 8'h00, busy_q, ovr_q, state_q, 8'h00, err_q};
   assign result_word = result_q;
   assign cnt_word    = {16'(errc_q), 16'(succ_q)};
   assign irq         = irq_q;
   assign cl_req      = (state_q == StIssue);
   assign cl_op       = op_q;
   assign cl_arg      = arg_q;

endmodule
